// File: rtl/ccff_shadow_mem.sv
`default_nettype none
// ============================================================================
// Module   : ccff_shadow_mem
// Purpose  : Configuration scan-chain memory with a commit-gated shadow
//            register, a saturating fill counter and a sticky overflow flag.
//            Config bits shift in serially on prog_clk; mem_out only changes
//            on a successful commit (or follows the chain in legacy mode).
// Revision : 1.0 - initial release
// ============================================================================
module ccff_shadow_mem #(
    parameter int                  NUM_BITS  = 4,
    parameter int                  SHADOW    = 1,
    parameter logic [0:NUM_BITS-1] RESET_VAL = '0
) (
    input  logic                            prog_clk,
    input  logic                            prog_reset_n,
    input  logic                            ccff_head,
    input  logic                            ccff_en,
    input  logic                            cfg_commit,
    output logic                            ccff_tail,
    output logic [0:NUM_BITS-1]             mem_out,
    output logic [0:NUM_BITS-1]             mem_outb,
    output logic                            cfg_ready,
    output logic                            cfg_overflow,
    output logic [$clog2(NUM_BITS+1)-1:0]   bit_count
);

    localparam int               CNT_W    = $clog2(NUM_BITS + 1);
    localparam logic [CNT_W-1:0] C_FULL   = CNT_W'(NUM_BITS);
    localparam logic             C_SHADOW = (SHADOW != 0);

    logic [0:NUM_BITS-1] chain_q;
    logic [0:NUM_BITS-1] chain_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                ovf_q;
    logic                ovf_d;

    logic w_full;
    logic w_ready;
    logic w_commit;
    logic w_clear;

    // A shift always takes priority, so a commit only counts with the chain idle.
    assign w_commit = cfg_commit & ~ccff_en;
    assign w_full   = (count_q == C_FULL);
    assign w_ready  = w_full & ~ovf_q;
    // Legacy mode may also recover from OVER by committing; shadowed mode may not.
    assign w_clear  = w_commit & (w_ready | (~C_SHADOW & ovf_q));

    // Next chain contents: new bit enters at index 0, everything moves one up.
    always_comb begin
        chain_d = chain_q;
        if (ccff_en) begin
            chain_d[0] = ccff_head;
            for (int i = 1; i < NUM_BITS; i++) begin
                chain_d[i] = chain_q[i-1];
            end
        end
    end

    // Fill counter saturates at NUM_BITS; any further shift marks overflow.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (ccff_en) begin
            if (w_full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (w_clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    // Chain, counter and overflow state registers.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            chain_q <= RESET_VAL;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            chain_q <= chain_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    generate
        if (SHADOW != 0) begin : g_shadow
            logic [0:NUM_BITS-1] shadow_q;
            logic [0:NUM_BITS-1] shadow_d;

            // Capture the whole frame at once, only when it is exactly full.
            always_comb begin
                shadow_d = shadow_q;
                if (w_commit & w_ready) begin
                    shadow_d = chain_q;
                end
            end

            // Shadow register feeding the datapath.
            always_ff @(posedge prog_clk or negedge prog_reset_n) begin
                if (!prog_reset_n) begin
                    shadow_q <= RESET_VAL;
                end else begin
                    shadow_q <= shadow_d;
                end
            end

            assign mem_out = shadow_q;
        end else begin : g_direct
            assign mem_out = chain_q;
        end
    endgenerate

    assign mem_outb     = ~mem_out;
    assign ccff_tail    = chain_q[NUM_BITS-1];
    assign cfg_ready    = w_ready;
    assign cfg_overflow = ovf_q;
    assign bit_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ccff_shadow_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_shadow_mem
// Purpose  : Self-checking bench for ccff_shadow_mem: shadowed 4-bit, legacy
//            4-bit cascade pair, and 1-bit shadowed instances against a
//            shift-count based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_shadow_mem;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: NUM_BITS=4, SHADOW=1, RESET_VAL=0
    logic       a_head = 1'b0, a_en = 1'b0, a_commit = 1'b0;
    logic       a_tail, a_ready, a_ovf;
    logic [0:3] a_mem_out, a_mem_outb;
    logic [2:0] a_bit_count;

    // Cascade pair: NUM_BITS=4, SHADOW=0, RESET_VAL=4'b1010
    logic       c_head = 1'b0, c_en = 1'b0, c_commit = 1'b0;
    logic       c0_tail, c0_ready, c0_ovf, c1_tail, c1_ready, c1_ovf;
    logic [0:3] c0_mem_out, c0_mem_outb, c1_mem_out, c1_mem_outb;
    logic [2:0] c0_bit_count, c1_bit_count;

    // Instance N: NUM_BITS=1, SHADOW=1, RESET_VAL=0
    logic       n_head = 1'b0, n_en = 1'b0, n_commit = 1'b0;
    logic       n_tail, n_ready, n_ovf;
    logic [0:0] n_mem_out, n_mem_outb;
    logic [0:0] n_bit_count;

    ccff_shadow_mem #(.NUM_BITS(4), .SHADOW(1), .RESET_VAL(4'b0000)) u_a (
        .prog_clk(clk), .prog_reset_n(rst_n), .ccff_head(a_head), .ccff_en(a_en),
        .cfg_commit(a_commit), .ccff_tail(a_tail), .mem_out(a_mem_out),
        .mem_outb(a_mem_outb), .cfg_ready(a_ready), .cfg_overflow(a_ovf),
        .bit_count(a_bit_count));

    ccff_shadow_mem #(.NUM_BITS(4), .SHADOW(0), .RESET_VAL(4'b1010)) u_c0 (
        .prog_clk(clk), .prog_reset_n(rst_n), .ccff_head(c_head), .ccff_en(c_en),
        .cfg_commit(c_commit), .ccff_tail(c0_tail), .mem_out(c0_mem_out),
        .mem_outb(c0_mem_outb), .cfg_ready(c0_ready), .cfg_overflow(c0_ovf),
        .bit_count(c0_bit_count));

    ccff_shadow_mem #(.NUM_BITS(4), .SHADOW(0), .RESET_VAL(4'b1010)) u_c1 (
        .prog_clk(clk), .prog_reset_n(rst_n), .ccff_head(c0_tail), .ccff_en(c_en),
        .cfg_commit(c_commit), .ccff_tail(c1_tail), .mem_out(c1_mem_out),
        .mem_outb(c1_mem_outb), .cfg_ready(c1_ready), .cfg_overflow(c1_ovf),
        .bit_count(c1_bit_count));

    ccff_shadow_mem #(.NUM_BITS(1), .SHADOW(1), .RESET_VAL(1'b0)) u_n (
        .prog_clk(clk), .prog_reset_n(rst_n), .ccff_head(n_head), .ccff_en(n_en),
        .cfg_commit(n_commit), .ccff_tail(n_tail), .mem_out(n_mem_out),
        .mem_outb(n_mem_outb), .cfg_ready(n_ready), .cfg_overflow(n_ovf),
        .bit_count(n_bit_count));

    // ------------------------------------------------------------------
    // Reference model: chain contents plus an unbounded count of shifts
    // since the last reset / successful commit. Count, ready and overflow
    // are all derived from that one number.
    // ------------------------------------------------------------------
    logic [0:3] m_a_chain, m_a_shadow, m_c0, m_c1;
    logic       m_n_chain, m_n_shadow;
    int         m_a_sh, m_c_sh, m_n_sh;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a_chain  <= 4'b0000;
            m_a_shadow <= 4'b0000;
            m_a_sh     <= 0;
            m_c0       <= 4'b1010;
            m_c1       <= 4'b1010;
            m_c_sh     <= 0;
            m_n_chain  <= 1'b0;
            m_n_shadow <= 1'b0;
            m_n_sh     <= 0;
        end else begin
            if (a_en) begin
                m_a_chain <= {a_head, m_a_chain[0:2]};
                m_a_sh    <= m_a_sh + 1;
            end else if (a_commit && m_a_sh == 4) begin
                m_a_shadow <= m_a_chain;
                m_a_sh     <= 0;
            end
            if (c_en) begin
                m_c0   <= {c_head, m_c0[0:2]};
                m_c1   <= {m_c0[3], m_c1[0:2]};
                m_c_sh <= m_c_sh + 1;
            end else if (c_commit && m_c_sh >= 4) begin
                m_c_sh <= 0;
            end
            if (n_en) begin
                m_n_chain <= n_head;
                m_n_sh    <= m_n_sh + 1;
            end else if (n_commit && m_n_sh == 1) begin
                m_n_shadow <= m_n_chain;
                m_n_sh     <= 0;
            end
        end
    end

    logic [0:3] e_a_outb, e_c0_outb, e_c1_outb;
    logic       e_n_outb;
    assign e_a_outb  = ~m_a_shadow;
    assign e_c0_outb = ~m_c0;
    assign e_c1_outb = ~m_c1;
    assign e_n_outb  = ~m_n_shadow;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output of every instance against the model each cycle.
    always @(negedge clk) begin
        chk("a_mem_out",   64'(a_mem_out),   64'(m_a_shadow));
        chk("a_mem_outb",  64'(a_mem_outb),  64'(e_a_outb));
        chk("a_tail",      64'(a_tail),      64'(m_a_chain[3]));
        chk("a_count",     64'(a_bit_count), 64'((m_a_sh > 4) ? 4 : m_a_sh));
        chk("a_ready",     64'(a_ready),     64'(m_a_sh == 4));
        chk("a_ovf",       64'(a_ovf),       64'(m_a_sh > 4));
        chk("c0_mem_out",  64'(c0_mem_out),  64'(m_c0));
        chk("c0_mem_outb", 64'(c0_mem_outb), 64'(e_c0_outb));
        chk("c0_tail",     64'(c0_tail),     64'(m_c0[3]));
        chk("c0_count",    64'(c0_bit_count), 64'((m_c_sh > 4) ? 4 : m_c_sh));
        chk("c0_ready",    64'(c0_ready),    64'(m_c_sh == 4));
        chk("c0_ovf",      64'(c0_ovf),      64'(m_c_sh > 4));
        chk("c1_mem_out",  64'(c1_mem_out),  64'(m_c1));
        chk("c1_mem_outb", 64'(c1_mem_outb), 64'(e_c1_outb));
        chk("c1_tail",     64'(c1_tail),     64'(m_c1[3]));
        chk("c1_count",    64'(c1_bit_count), 64'((m_c_sh > 4) ? 4 : m_c_sh));
        chk("c1_ready",    64'(c1_ready),    64'(m_c_sh == 4));
        chk("c1_ovf",      64'(c1_ovf),      64'(m_c_sh > 4));
        chk("n_mem_out",   64'(n_mem_out),   64'(m_n_shadow));
        chk("n_mem_outb",  64'(n_mem_outb),  64'(e_n_outb));
        chk("n_tail",      64'(n_tail),      64'(m_n_chain));
        chk("n_count",     64'(n_bit_count), 64'((m_n_sh > 1) ? 1 : m_n_sh));
        chk("n_ready",     64'(n_ready),     64'(m_n_sh == 1));
        chk("n_ovf",       64'(n_ovf),       64'(m_n_sh > 1));
    end

    // Each step applies inputs for one rising edge and returns just after the
    // following falling edge, where outputs reflect that edge.
    task automatic a_step(input logic h, input logic e, input logic c);
        a_head = h; a_en = e; a_commit = c;
        @(negedge clk); #1;
        a_en = 1'b0; a_commit = 1'b0;
    endtask

    task automatic c_step(input logic h, input logic e, input logic c);
        c_head = h; c_en = e; c_commit = c;
        @(negedge clk); #1;
        c_en = 1'b0; c_commit = 1'b0;
    endtask

    task automatic n_step(input logic h, input logic e, input logic c);
        n_head = h; n_en = e; n_commit = c;
        @(negedge clk); #1;
        n_en = 1'b0; n_commit = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk); #1;
        // Reset state
        chk("rst_a_mem_out",  64'(a_mem_out),   64'(4'b0000));
        chk("rst_a_mem_outb", 64'(a_mem_outb),  64'(4'b1111));
        chk("rst_a_count",    64'(a_bit_count), 64'(0));
        chk("rst_a_ready",    64'(a_ready),     64'(0));
        rst_n = 1'b1;

        // Basic frame 1,0,1,1 then commit
        a_step(1, 1, 0); a_step(0, 1, 0); a_step(1, 1, 0); a_step(1, 1, 0);
        chk("t1_count",       64'(a_bit_count), 64'(4));
        chk("t1_ready",       64'(a_ready),     64'(1));
        chk("t1_pre_mem",     64'(a_mem_out),   64'(4'b0000));
        chk("t1_tail",        64'(a_tail),      64'(1));
        a_step(0, 0, 1);
        chk("t1_mem_out",     64'(a_mem_out),   64'(4'b1101));
        chk("t1_mem_outb",    64'(a_mem_outb),  64'(4'b0010));
        chk("t1_count_clr",   64'(a_bit_count), 64'(0));

        // Premature commit after 3 shifts
        do_reset();
        a_step(0, 1, 0); a_step(1, 1, 0); a_step(1, 1, 0);
        a_step(0, 0, 1);
        chk("t2_mem_hold",    64'(a_mem_out),   64'(4'b0000));
        chk("t2_count",       64'(a_bit_count), 64'(3));
        chk("t2_ready",       64'(a_ready),     64'(0));
        a_step(0, 1, 0);
        a_step(0, 0, 1);
        chk("t2_mem_out",     64'(a_mem_out),   64'(4'b0110));

        // Overflow: five shifts, commit ignored, then reset clears it
        a_step(1, 1, 0); a_step(1, 1, 0); a_step(1, 1, 0); a_step(1, 1, 0);
        a_step(0, 1, 0);
        chk("t3_ovf",         64'(a_ovf),       64'(1));
        chk("t3_ready",       64'(a_ready),     64'(0));
        chk("t3_count",       64'(a_bit_count), 64'(4));
        a_step(0, 0, 1);
        chk("t3_mem_hold",    64'(a_mem_out),   64'(4'b0110));
        chk("t3_ovf_sticky",  64'(a_ovf),       64'(1));
        do_reset();
        chk("t3_rst_mem",     64'(a_mem_out),   64'(4'b0000));
        chk("t3_rst_ovf",     64'(a_ovf),       64'(0));

        // Simultaneous commit + shift while READY
        a_step(1, 1, 0); a_step(0, 1, 0); a_step(0, 1, 0); a_step(1, 1, 0);
        a_step(1, 1, 1);
        chk("t4_ovf",         64'(a_ovf),       64'(1));
        chk("t4_count",       64'(a_bit_count), 64'(4));
        chk("t4_mem_hold",    64'(a_mem_out),   64'(4'b0000));
        chk("t4_tail",        64'(a_tail),      64'(0));

        // Asynchronous reset between clock edges, mid-frame
        do_reset();
        a_step(1, 1, 0); a_step(0, 1, 0); a_step(1, 1, 0); a_step(1, 1, 0);
        a_step(0, 0, 1);
        a_step(1, 1, 0); a_step(1, 1, 0);
        chk("t5_pre_count",   64'(a_bit_count), 64'(2));
        chk("t5_pre_tail",    64'(a_tail),      64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_mem",   64'(a_mem_out),   64'(4'b0000));
        chk("t5_async_outb",  64'(a_mem_outb),  64'(4'b1111));
        chk("t5_async_count", 64'(a_bit_count), 64'(0));
        chk("t5_async_tail",  64'(a_tail),      64'(0));
        #1 rst_n = 1'b1;
        @(negedge clk); #1;

        // Legacy mode cascade, RESET_VAL 1010
        do_reset();
        chk("t6_c0_rst",      64'(c0_mem_out),  64'(4'b1010));
        chk("t6_c1_rst",      64'(c1_mem_out),  64'(4'b1010));
        chk("t6_c0_tail_rst", 64'(c0_tail),     64'(0));
        c_step(1, 1, 0);
        chk("t6_c0_live",     64'(c0_mem_out),  64'(4'b1101));
        chk("t6_c1_live",     64'(c1_mem_out),  64'(4'b0101));
        c_step(1, 1, 0); c_step(0, 1, 0); c_step(1, 1, 0);
        c_step(0, 1, 0); c_step(0, 1, 0); c_step(1, 1, 0); c_step(1, 1, 0);
        chk("t6_c0_final",    64'(c0_mem_out),  64'(4'b1100));
        chk("t6_c1_final",    64'(c1_mem_out),  64'(4'b1011));
        chk("t6_c0_ovf",      64'(c0_ovf),      64'(1));
        c_step(0, 0, 1);
        chk("t6_clr_ovf",     64'(c0_ovf),      64'(0));
        chk("t6_clr_count",   64'(c0_bit_count), 64'(0));
        chk("t6_chain_kept",  64'(c0_mem_out),  64'(4'b1100));

        // Single-bit chain
        do_reset();
        n_step(1, 1, 0);
        chk("t7_ready",       64'(n_ready),     64'(1));
        chk("t7_count",       64'(n_bit_count), 64'(1));
        chk("t7_mem_pre",     64'(n_mem_out),   64'(0));
        n_step(0, 0, 1);
        chk("t7_mem",         64'(n_mem_out),   64'(1));
        chk("t7_count_clr",   64'(n_bit_count), 64'(0));
        n_step(0, 1, 0);
        n_step(1, 1, 0);
        chk("t7_ovf",         64'(n_ovf),       64'(1));
        chk("t7_not_ready",   64'(n_ready),     64'(0));
        n_step(0, 0, 1);
        chk("t7_mem_hold",    64'(n_mem_out),   64'(1));

        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
